// File: rtl/requant_pkg.sv
// Shared widths and helpers for the requantizer: default sizes, saturating clip
// and a popcount of per-lane saturation flags.
package requant_pkg;

  localparam int DEF_ACC_W   = 32;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_LANES   = 4;
  localparam int DEF_MULT_W  = 16;
  localparam int DEF_SHIFT_W = 6;
  localparam int DEF_CNT_W   = 16;

  // Scratch width for the clip; must hold ACC_W+MULT_W+2 bits.
  localparam int WIDE_W    = 64;
  localparam int MAX_LANES = 32;

  function automatic logic signed [WIDE_W-1:0] sat_clip(
    input logic signed [WIDE_W-1:0] value,
    input int                       data_w
  );
    logic signed [WIDE_W-1:0] max_v;
    logic signed [WIDE_W-1:0] min_v;
    max_v = $signed((WIDE_W'(1) << (data_w - 1)) - WIDE_W'(1));
    min_v = ~max_v;
    if (value > max_v)      sat_clip = max_v;
    else if (value < min_v) sat_clip = min_v;
    else                    sat_clip = value;
  endfunction

  function automatic int unsigned popcount(input logic [MAX_LANES-1:0] flags);
    popcount = 0;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (flags[i]) popcount++;
    end
  endfunction

endpackage

// File: rtl/requant_lane.sv
// One lane of the requantizer: S1 multiply, S2 round-and-shift, S3 saturate/ReLU.
// Stage enables and per-beat shift/relu are supplied by the top level.
module requant_lane
  import requant_pkg::*;
#(
  parameter int ACC_W   = DEF_ACC_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MULT_W  = DEF_MULT_W,
  parameter int SHIFT_W = DEF_SHIFT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_en1,
  input  logic                     i_en2,
  input  logic                     i_en3,
  input  logic signed [ACC_W-1:0]  i_acc,
  input  logic        [MULT_W-1:0] i_mult,
  input  logic       [SHIFT_W-1:0] i_shift,
  input  logic                     i_relu,
  output logic        [DATA_W-1:0] o_data,
  output logic                     o_sat
);

  localparam int PROD_W = ACC_W + MULT_W + 1;

  logic signed [PROD_W-1:0] w_prod;
  logic signed [PROD_W-1:0] r_prod;
  logic signed [PROD_W:0]   w_prod_ext;
  logic signed [PROD_W:0]   w_round;
  logic signed [PROD_W:0]   w_sum;
  logic signed [PROD_W:0]   w_scaled;
  logic signed [PROD_W:0]   r_scaled;
  logic signed [WIDE_W-1:0] w_wide;
  logic signed [WIDE_W-1:0] w_clip;
  logic        [DATA_W-1:0] w_out;
  logic        [DATA_W-1:0] r_data;

  assign w_prod     = i_acc * $signed({1'b0, i_mult});
  assign w_prod_ext = {r_prod[PROD_W-1], r_prod};
  // Adding half an LSB before the arithmetic shift rounds half toward +inf.
  assign w_round    = (i_shift != '0) ? ((PROD_W+1)'(1) << (i_shift - SHIFT_W'(1))) : '0;
  assign w_sum      = w_prod_ext + w_round;
  assign w_scaled   = w_sum >>> i_shift;

  assign w_wide = {{(WIDE_W-PROD_W-1){r_scaled[PROD_W]}}, r_scaled};
  assign w_clip = sat_clip(w_wide, DATA_W);
  assign o_sat  = (w_clip != w_wide);
  assign w_out  = (i_relu && w_clip[WIDE_W-1]) ? '0 : w_clip[DATA_W-1:0];

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod   <= '0;
      r_scaled <= '0;
      r_data   <= '0;
    end else begin
      if (i_en1) r_prod   <= w_prod;
      if (i_en2) r_scaled <= w_scaled;
      if (i_en3) r_data   <= w_out;
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/requant_pipe.sv
// Multi-lane requantizer top: stage valid bits, valid/ready handshake, per-beat
// sideband pipeline and the sticky saturation counter.
module requant_pipe
  import requant_pkg::*;
#(
  parameter int ACC_W   = DEF_ACC_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int LANES   = DEF_LANES,
  parameter int MULT_W  = DEF_MULT_W,
  parameter int SHIFT_W = DEF_SHIFT_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*ACC_W-1:0]    in_acc,
  input  logic [MULT_W-1:0]         in_mult,
  input  logic [SHIFT_W-1:0]        in_shift,
  input  logic                      in_relu,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DATA_W-1:0]   out_data,
  output logic                      out_last,
  input  logic                      clr_stats,
  output logic [CNT_W-1:0]          sat_count
);

  logic               r_v1, r_v2, r_v3;
  logic               w_adv1, w_adv2, w_adv3;
  logic               w_en1, w_en2, w_en3;
  logic [SHIFT_W-1:0] r_shift1;
  logic               r_relu1, r_relu2;
  logic               r_last1, r_last2, r_last3;
  logic [LANES-1:0]   w_sat;
  logic [CNT_W:0]     w_cnt_sum;
  logic [CNT_W-1:0]   w_cnt_next;
  logic [CNT_W-1:0]   r_sat_count;

  // A stage may load when it is empty or its content moves on this cycle.
  assign w_adv3   = !r_v3 || out_ready;
  assign w_adv2   = !r_v2 || w_adv3;
  assign w_adv1   = !r_v1 || w_adv2;
  assign in_ready = w_adv1;

  assign w_en1 = in_valid && w_adv1;
  assign w_en2 = r_v1 && w_adv2;
  assign w_en3 = r_v2 && w_adv3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1     <= 1'b0;
      r_v2     <= 1'b0;
      r_v3     <= 1'b0;
      r_shift1 <= '0;
      r_relu1  <= 1'b0;
      r_relu2  <= 1'b0;
      r_last1  <= 1'b0;
      r_last2  <= 1'b0;
      r_last3  <= 1'b0;
    end else begin
      if (w_adv1) r_v1 <= in_valid;
      if (w_adv2) r_v2 <= r_v1;
      if (w_adv3) r_v3 <= r_v2;
      if (w_en1) begin
        r_shift1 <= in_shift;
        r_relu1  <= in_relu;
        r_last1  <= in_last;
      end
      if (w_en2) begin
        r_relu2 <= r_relu1;
        r_last2 <= r_last1;
      end
      if (w_en3) r_last3 <= r_last2;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    requant_lane #(
      .ACC_W   (ACC_W),
      .DATA_W  (DATA_W),
      .MULT_W  (MULT_W),
      .SHIFT_W (SHIFT_W)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_en1   (w_en1),
      .i_en2   (w_en2),
      .i_en3   (w_en3),
      .i_acc   (in_acc[g*ACC_W +: ACC_W]),
      .i_mult  (in_mult),
      .i_shift (r_shift1),
      .i_relu  (r_relu2),
      .o_data  (out_data[g*DATA_W +: DATA_W]),
      .o_sat   (w_sat[g])
    );
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_cnt_next = r_sat_count;
    w_cnt_sum  = {1'b0, r_sat_count} + (CNT_W+1)'(popcount(MAX_LANES'(w_sat)));
    if (w_en3) w_cnt_next = w_cnt_sum[CNT_W] ? '1 : w_cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_sat_count <= '0;
    else if (clr_stats) r_sat_count <= '0;
    else                r_sat_count <= w_cnt_next;
  end

  assign out_valid = r_v3;
  assign out_last  = r_last3;
  assign sat_count = r_sat_count;

endmodule

// File: doc/requant_pipe.md
# requant_pipe

Pipelined, multi-lane requantizer that converts signed accumulator outputs from the DSCNN MAC array into saturated signed activations. It sits between the accumulator bank and the activation buffer. It adds per-beat fixed-point scaling (multiplier plus shift), round-half-up, optional ReLU, valid/ready flow control and a saturation statistics counter. It processes LANES accumulators per beat at one beat per clock.

## Interface
- ACC_W, 32, accumulator width (signed)
- DATA_W, 8, output activation width (signed)
- LANES, 4, accumulators processed per beat
- MULT_W, 16, unsigned scale multiplier width
- SHIFT_W, 6, right-shift amount width
- CNT_W, 16, saturation counter width
- clk  in  1  sole clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat this cycle
- in_acc  in  LANES*ACC_W  packed signed accumulators, lane 0 in LSBs
- in_mult  in  MULT_W  unsigned multiplier, applies to all lanes of the beat
- in_shift  in  SHIFT_W  right-shift amount, 0..ACC_W+MULT_W-1
- in_relu  in  1  clamp negatives to 0 for this beat
- in_last  in  1  sideband marking the last beat of a layer, passed through
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts the beat
- out_data  out  LANES*DATA_W  packed signed results, lane 0 in LSBs
- out_last  out  1  delayed in_last
- clr_stats  in  1  synchronous clear of sat_count
- sat_count  out  CNT_W  number of lanes saturated since the last clear, sticky at max

## Operation
- A beat is accepted when in_valid && in_ready. Its mult, shift, relu and last values travel with the data; no global configuration registers.
- Per-lane datapath, with PROD_W = ACC_W+MULT_W+1:
  - S1: prod = acc × {0,mult}, signed, PROD_W bits.
  - S2: if shift>0, add 2^(shift-1) in PROD_W+1 bits, then arithmetic shift right by shift. If shift=0, pass unchanged. This is round half toward +inf.
  - S3: saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1], then apply ReLU if enabled, so negatives become 0.
- Saturation is detected before ReLU. A value clamped only by ReLU is not counted as saturation.
- sat_count adds the number of saturated lanes (0..LANES) of each beat when that beat leaves S3 into the output register.
  - It saturates at 2^CNT_W-1 and does not wrap.
  - clr_stats has priority: in the clear cycle the count becomes 0 and that cycle's increment is discarded.
- Results leave in acceptance order. No beat is dropped or duplicated under any out_ready pattern.

## Timing
- Three register stages (S1, S2, S3 = output register). Latency is 3 cycles from acceptance to out_valid when out_ready is held high.
- Throughput is 1 beat/cycle when out_ready=1.
- Each stage holds a valid bit and advances when the next stage is empty or advancing.
- in_ready = !v1 || !v2 || !v3 || out_ready. This is a combinational ripple and has no combinational path from in_valid.
- With out_ready low, the pipeline fills and absorbs 3 beats, then in_ready drops. out_data, out_last and out_valid stay stable while out_valid && !out_ready.
- Reset values:
  - all stage valid bits 0
  - out_valid 0
  - out_data 0
  - out_last 0
  - sat_count 0
  - in_ready 1 after reset release
- Reset asserted mid-stream discards all in-flight beats immediately.

## Structure
- Shared package requant_pkg holds:
  - default width localparams
  - function sat_clip(value, DATA_W)
  - function popcount of per-lane saturation flags
- Sub-module requant_lane: one lane's S1–S3 datapath registers with a shared stage-enable input and a sat flag output. It is instantiated LANES times by generate.
- Top level requant_pipe owns the valid bits, handshake, sideband pipeline and sat_count.

## Test plan
- Rounding: acc=1000, mult=16384, shift=20, relu=0 → out=16 (15.625 rounds up); acc=-3, mult=1, shift=1 → -1; sat_count unchanged.
- Saturation: lane0 acc=100000, lane1 acc=-100000, mult=1, shift=0 → 127 and -128; sat_count increments by 2.
- ReLU: acc=-300, mult=1, shift=1, relu=1 → 0 and sat_count +1 (pre-ReLU value -150 saturated); acc=-20, relu=1 → 0 and sat_count +0.
- Backpressure: stream beats 1..10 continuously with out_ready low for cycles 4–9 → in_ready low after 3 held beats, all 10 outputs in order, out_data stable while stalled, out_last aligned to beat 10.
- Counter limits: CNT_W=4 and force 20 saturating lanes → sat_count holds 15; clr_stats pulsed together with a saturating beat → sat_count reads 0.
- Reset mid-stream: assert rst_n low with 3 beats in flight → out_valid=0, out_data=0 and sat_count=0 immediately; after release, the first new beat appears 3 cycles after acceptance.
